psram_sample_ring: RTL and testbench

//  Upstream command sequencer for the async PSRAM controller: turns a 16-bit audio sample stream into a ring-buffer delay line in PSRAM.

---
 rtl/psram_sample_ring.sv | 133 +++++++++++++
 tb/tb_psram_sample_ring.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_sample_ring.sv
// psram_sample_ring: turns a 16-bit sample stream into a PSRAM ring-buffer delay line (write, then read back delay words older).
// Ports: sysclk/rst (async active-low); enable, in_sample, in_valid, delay: sample input side;
//        out_sample, out_valid: delayed sample output; overrun, fault, clear_flags: sticky status;
//        mem_data_out, mem_addr, mem_byte_en, command, go, mem_idle, mem_data_in: PSRAM controller handshake.
module psram_sample_ring #(
    parameter int          RING_BITS  = 16,
    parameter logic [25:0] BASE_ADDR  = 26'h0,
    parameter int          GO_TIMEOUT = 15
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [15:0]          in_sample,
    input  logic                 in_valid,
    input  logic [RING_BITS-1:0] delay,
    output logic [15:0]          out_sample,
    output logic                 out_valid,
    output logic                 overrun,
    output logic                 fault,
    input  logic                 clear_flags,
    output logic [15:0]          mem_data_out,
    output logic [25:0]          mem_addr,
    output logic [1:0]           mem_byte_en,
    output logic                 command,
    output logic                 go,
    input  logic                 mem_idle,
    input  logic [15:0]          mem_data_in
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam int TW = $clog2(GO_TIMEOUT + 1);

    logic [2:0]           state;
    logic [15:0]          hold;
    logic                 pending;
    logic [RING_BITS-1:0] wr_ptr, fill, rd_ptr;
    logic [TW-1:0]        tmo;
    logic                 take, req, skip, expire, commit;

    assign take   = in_valid & enable;
    assign req    = (state == WR_REQ) || (state == RD_REQ);
    assign rd_ptr = wr_ptr - delay;
    // delay beyond the written history: nothing valid to read yet
    assign skip   = delay > fill;
    // go still unaccepted (controller kept mem_idle high) for GO_TIMEOUT cycles
    assign expire = req && mem_idle && (tmo == TW'(GO_TIMEOUT - 1));
    assign commit = mem_idle && (((state == WR_WAIT) && skip) || (state == RD_WAIT));

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            hold    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            fault   <= 1'b0;
        end else begin
            hold    <= take ? in_sample : hold;
            // a sample landing on the commit/abort cycle simply becomes the next pending one
            pending <= take | (pending & ~(commit | expire));
            overrun <= (take & pending & ~(commit | expire)) | (overrun & ~clear_flags);
            fault   <= expire | (fault & ~clear_flags);
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            go           <= 1'b0;
            command      <= 1'b1;
            mem_addr     <= '0;
            mem_byte_en  <= 2'b11;
            mem_data_out <= '0;
            out_sample   <= '0;
            out_valid    <= 1'b0;
            wr_ptr       <= '0;
            fill         <= '0;
            tmo          <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (pending && mem_idle) begin
                    state        <= WR_REQ;
                    go           <= 1'b1;
                    command      <= 1'b0;
                    mem_byte_en  <= 2'b00;
                    mem_data_out <= hold;
                    mem_addr     <= BASE_ADDR + 26'(wr_ptr);
                    tmo          <= '0;
                end
                // the controller ignores go during its post-op hold, so keep asking until mem_idle drops
                WR_REQ, RD_REQ: if (!mem_idle) begin
                    state <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
                    go    <= 1'b0;
                end else if (expire) begin
                    state       <= IDLE;
                    go          <= 1'b0;
                    command     <= 1'b1;
                    mem_byte_en <= 2'b11;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                WR_WAIT: if (mem_idle) begin
                    if (skip) begin
                        state       <= IDLE;
                        out_sample  <= '0;
                        out_valid   <= 1'b1;
                        command     <= 1'b1;
                        mem_byte_en <= 2'b11;
                    end else begin
                        state    <= RD_REQ;
                        go       <= 1'b1;
                        command  <= 1'b1;
                        mem_addr <= BASE_ADDR + 26'(rd_ptr);
                        tmo      <= '0;
                    end
                end
                RD_WAIT: if (mem_idle) begin
                    state       <= IDLE;
                    out_sample  <= mem_data_in;
                    out_valid   <= 1'b1;
                    mem_byte_en <= 2'b11;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill   <= (&fill) ? fill : fill + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_psram_sample_ring.sv
// tb_psram_sample_ring: scoreboard bench for psram_sample_ring with a behavioural PSRAM controller model.
module tb_psram_sample_ring;
    localparam int          RB   = 4;
    localparam logic [25:0] BASE = 26'h00000A0;
    localparam int          GT   = 15;

    logic          sysclk = 1'b0, rst = 1'b1, enable = 1'b0, in_valid = 1'b0, clear_flags = 1'b0, mem_idle = 1'b1;
    logic [15:0]   in_sample = '0, mem_data_in = '0;
    logic [RB-1:0] delay = '0;
    logic [15:0]   out_sample, mem_data_out;
    logic          out_valid, overrun, fault, command, go;
    logic [25:0]   mem_addr;
    logic [1:0]    mem_byte_en;

    int n_chk = 0, n_fail = 0;
    int n_reads = 0, exp_reads = 0, n_ov = 0, go_cycles = 0;
    logic [15:0] exp_q[$];
    logic [15:0] hist[$];
    logic [25:0] wa_q[$];
    logic [25:0] ra_q[$];

    int          busy = 0, hold = 0;
    bit          stuck = 1'b0;
    logic        c_cmd = 1'b0;
    logic [25:0] c_addr = '0;
    logic [15:0] c_data = '0;
    logic [15:0] pmem[int];

    always #5 sysclk = ~sysclk;

    psram_sample_ring #(.RING_BITS(RB), .BASE_ADDR(BASE), .GO_TIMEOUT(GT)) dut (
        .sysclk(sysclk), .rst(rst), .enable(enable), .in_sample(in_sample), .in_valid(in_valid),
        .delay(delay), .out_sample(out_sample), .out_valid(out_valid), .overrun(overrun), .fault(fault),
        .clear_flags(clear_flags), .mem_data_out(mem_data_out), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .command(command), .go(go), .mem_idle(mem_idle), .mem_data_in(mem_data_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // PSRAM controller: accepts go only when idle and out of hold, 10 busy cycles, then 3 hold cycles with mem_idle=1
    always @(negedge sysclk) begin
        if (!rst) begin
            busy = 0;
            hold = 0;
            mem_idle = 1'b1;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                if (c_cmd) mem_data_in = pmem.exists(int'(c_addr)) ? pmem[int'(c_addr)] : 16'hdead;
                else pmem[int'(c_addr)] = c_data;
                mem_idle = 1'b1;
                hold = 3;
            end
        end else if (stuck) begin
            mem_idle = 1'b1;
        end else if (hold > 0) begin
            hold--;
        end else if (go) begin
            c_cmd = command;
            c_addr = mem_addr;
            c_data = mem_data_out;
            busy = 10;
            mem_idle = 1'b0;
            check("byte_en", 32'(mem_byte_en), 32'd0);
            if (command) begin
                n_reads++;
                if (ra_q.size() == 0) miss("unexpected_read", 32'(mem_addr));
                else check("rd_addr", 32'(mem_addr), 32'(ra_q.pop_front()));
            end else begin
                if (wa_q.size() == 0) miss("unexpected_write", 32'(mem_addr));
                else check("wr_addr", 32'(mem_addr), 32'(wa_q.pop_front()));
            end
        end
    end

    always @(negedge sysclk) begin
        if (rst) begin
            if (go) go_cycles++;
            if (out_valid) begin
                n_ov++;
                if (exp_q.size() == 0) miss("unexpected_out", 32'(out_sample));
                else check("out_sample", 32'(out_sample), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pulse(input logic [15:0] v);
        @(negedge sysclk);
        in_sample = v;
        in_valid = 1'b1;
        @(negedge sysclk);
        in_valid = 1'b0;
    endtask

    // reference: sample n goes to ring slot n mod 16; output is sample n-delay, or 0 if that is before history
    task automatic expect_sample(input logic [15:0] v);
        int n = hist.size();
        int d = int'(delay);
        hist.push_back(v);
        wa_q.push_back(BASE + 26'(n % (1 << RB)));
        if (d > n) exp_q.push_back(16'h0);
        else begin
            ra_q.push_back(BASE + 26'((n - d) % (1 << RB)));
            exp_q.push_back(hist[n - d]);
            exp_reads++;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || wa_q.size() != 0 || ra_q.size() != 0) && t < 400) begin
            @(negedge sysclk);
            t++;
        end
        if (t >= 400) miss("drain_timeout", 32'(exp_q.size()));
        tick(2);
    endtask

    task automatic send(input logic [15:0] v);
        expect_sample(v);
        pulse(v);
        drain();
    endtask

    task automatic flush();
        exp_q.delete();
        wa_q.delete();
        ra_q.delete();
        hist.delete();
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst = 1'b0;
        flush();
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic clear();
        @(negedge sysclk);
        clear_flags = 1'b1;
        @(negedge sysclk);
        clear_flags = 1'b0;
    endtask

    initial begin
        int r0;
        int t;
        #2 rst = 1'b0;
        tick(3);
        check("rst_go", 32'(go), 32'd0);
        check("rst_command", 32'(command), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_byte_en", 32'(mem_byte_en), 32'd3);
        check("rst_data_out", 32'(mem_data_out), 32'd0);
        check("rst_out_sample", 32'(out_sample), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {30'd0, overrun, fault}, 32'd0);
        rst = 1'b1;
        enable = 1'b1;
        tick(2);

        delay = 0;
        send(16'h1234);
        check("t1_pulses", 32'(n_ov), 32'd1);
        check("t1_reads", 32'(n_reads), 32'd1);
        check("t1_idle_byte_en", 32'(mem_byte_en), 32'd3);

        do_reset();
        delay = 3;
        r0 = n_reads;
        for (int i = 1; i <= 6; i++) send(16'(i));
        check("t2_reads", 32'(n_reads - r0), 32'd3);

        do_reset();
        delay = 2;
        for (int i = 0; i < 20; i++) send(16'($urandom));
        check("t3_reads", 32'(n_reads), 32'(exp_reads));

        for (int i = 0; i < 30; i++) begin
            delay = RB'($urandom_range(0, (1 << RB) - 1));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                pulse(16'($urandom));
                tick(40);
                enable = 1'b1;
            end
            send(16'($urandom));
            tick($urandom_range(0, 20));
        end
        check("rand_reads", 32'(n_reads), 32'(exp_reads));

        delay = 1;
        expect_sample(16'haaaa);
        pulse(16'haaaa);
        pulse(16'hbbbb);
        tick(1);
        check("t4_overrun_set", 32'(overrun), 32'd1);
        drain();
        tick(60);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        clear();
        check("t4_overrun_clear", 32'(overrun), 32'd0);

        stuck = 1'b1;
        go_cycles = 0;
        r0 = n_reads;
        pulse(16'h5555);
        t = 0;
        while (!fault && t < 100) begin
            @(negedge sysclk);
            t++;
        end
        check("t5_fault", 32'(fault), 32'd1);
        tick(1);
        check("t5_go_low", 32'(go), 32'd0);
        check("t5_go_cycles", 32'(go_cycles), 32'(GT));
        check("t5_idle_cmd", {30'd0, command, 1'b0} | 32'(mem_byte_en == 2'b11), 32'd3);
        stuck = 1'b0;
        tick(50);
        check("t5_no_read", 32'(n_reads - r0), 32'd0);
        check("t5_fault_sticky", 32'(fault), 32'd1);
        clear();
        check("t5_fault_clear", 32'(fault), 32'd0);
        delay = 0;
        send(16'h7777);

        expect_sample(16'h1111);
        pulse(16'h1111);
        pulse(16'h2222);
        t = 0;
        while (!(busy > 0 && c_cmd) && t < 200) begin
            @(negedge sysclk);
            t++;
        end
        if (t >= 200) miss("t6_wait_read", 32'(t));
        @(posedge sysclk);
        #2;
        check("t6_pre_overrun", 32'(overrun), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_go", 32'(go), 32'd0);
        check("t6_flags", {30'd0, overrun, fault}, 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        flush();
        tick(3);
        rst = 1'b1;
        tick(2);
        r0 = n_ov;
        send(16'hbeef);
        check("t6_pulses", 32'(n_ov - r0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
